// File: rtl/bomb_controller.sv
// Single-bomb sequencer for Bomberman: hitbox-centre tile snap, fuse timer, explosion window and pixel overlap.
// Optional remote detonation when BOMB_REMOTE_EN is defined.
module bomb_controller #(
  parameter int FUSE_CYCLES = 150000000,
  parameter int EXP_CYCLES  = 50000000,
  parameter int EXP_RANGE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       gameover,
  input  logic [9:0] x_b,
  input  logic [9:0] y_b,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       bomb_active,
  output logic       exp_active,
  output logic       exp_start,
  output logic [5:0] bomb_col,
  output logic [4:0] bomb_row,
  output logic       bomb_on,
  output logic       exp_on
);

  localparam int MAX_CYCLES = (FUSE_CYCLES > EXP_CYCLES) ? FUSE_CYCLES : EXP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FUSE_LOAD = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_LOAD  = CNT_W'(EXP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FUSE, EXPLODE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             a_p0, a_p1, a_p2;
  logic             place_req;
  logic             remote_det;

  assign place_req = a_p1 & ~a_p2;

`ifdef BOMB_REMOTE_EN
  assign remote_det = place_req;
`else
  assign remote_det = 1'b0;
`endif

  // Synchronizer stages, then the FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0        <= 1'b0;
      a_p1        <= 1'b0;
      a_p2        <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      bomb_col    <= '0;
      bomb_row    <= '0;
      bomb_active <= 1'b0;
      exp_active  <= 1'b0;
      exp_start   <= 1'b0;
    end else begin
      a_p0      <= A;
      a_p1      <= a_p0;
      a_p2      <= a_p1;
      exp_start <= 1'b0;
      if (gameover) begin
        state       <= IDLE;
        cnt         <= '0;
        bomb_active <= 1'b0;
        exp_active  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (place_req) begin
              state       <= FUSE;
              cnt         <= FUSE_LOAD;
              // Snap the hitbox centre (sprite offset 8,17) onto the arena grid at (48,32)
              bomb_col    <= 6'((x_b + 10'd8 - 10'd48) >> 4);
              bomb_row    <= 5'((y_b + 10'd17 - 10'd32) >> 4);
              bomb_active <= 1'b1;
            end
          end
          FUSE: begin
            if (cnt == '0 || remote_det) begin
              state       <= EXPLODE;
              cnt         <= EXP_LOAD;
              bomb_active <= 1'b0;
              exp_active  <= 1'b1;
              exp_start   <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          EXPLODE: begin
            if (cnt == '0) begin
              state      <= IDLE;
              exp_active <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [9:0] x_off, y_off;
  logic       pix_ok;
  logic       centre_hit;
  logic       arm_hit;
  logic       alive;
  int         pix_col, pix_row, tc, tr;

  assign x_off  = x - 10'd48;
  assign y_off  = y - 10'd32;
  assign pix_ok = (x >= 10'd48) && (y >= 10'd32);

  // Walk each arm outward; the first off-grid or pillar tile blocks the rest of that arm
  always_comb begin
    pix_col    = int'(x_off) / 16;
    pix_row    = int'(y_off) / 16;
    centre_hit = pix_ok && (pix_col == int'(bomb_col)) && (pix_row == int'(bomb_row));
    arm_hit    = 1'b0;
    alive      = 1'b0;
    tc         = 0;
    tr         = 0;
    for (int d = 0; d < 4; d++) begin
      alive = 1'b1;
      for (int k = 1; k <= EXP_RANGE; k++) begin
        tc = int'(bomb_col) + ((d == 0) ? k : ((d == 1) ? -k : 0));
        tr = int'(bomb_row) + ((d == 2) ? k : ((d == 3) ? -k : 0));
        if (tc < 0 || tc > 32 || tr < 0 || tr > 25 || (tc[0] && tr[0]))
          alive = 1'b0;
        if (alive && pix_ok && (pix_col == tc) && (pix_row == tr))
          arm_hit = 1'b1;
      end
    end
  end

  assign bomb_on = bomb_active & centre_hit;
  assign exp_on  = exp_active & (centre_hit | arm_hit);

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: timing sequences, tile scoreboard and pixel vector table.
module tb_bomb_controller;

  localparam int FUSE = 10;
  localparam int EXPC = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       A;
  logic       gameover;
  logic [9:0] x_b, y_b, x, y;
  logic       bomb_active, exp_active, exp_start, bomb_on, exp_on;
  logic [5:0] bomb_col;
  logic [4:0] bomb_row;

  bomb_controller #(.FUSE_CYCLES(FUSE), .EXP_CYCLES(EXPC), .EXP_RANGE(1)) dut (
    .clk(clk), .reset(reset), .A(A), .gameover(gameover),
    .x_b(x_b), .y_b(y_b), .x(x), .y(y),
    .bomb_active(bomb_active), .exp_active(exp_active), .exp_start(exp_start),
    .bomb_col(bomb_col), .bomb_row(bomb_row), .bomb_on(bomb_on), .exp_on(exp_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   col;
    int   row;
  } tile_t;

  typedef struct {
    int         grp;
    int         kind;
    logic [9:0] px;
    logic [9:0] py;
    int         want;
  } vec_t;

  tile_t sb[$];
  vec_t  vecs[27];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic place_expect(input int col, input int row);
    tile_t t;
    t.col = col;
    t.row = row;
    sb.push_back(t);
  endtask

  task automatic wait_bomb();
    tile_t t;
    for (int g = 0; g < 50 && !bomb_active; g++) tick();
    chk("bomb_active_timeout", int'(bomb_active), 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      t = sb.pop_front();
      chk("bomb_col", int'(bomb_col), t.col);
      chk("bomb_row", int'(bomb_row), t.row);
    end
  endtask

  task automatic wait_exp();
    for (int g = 0; g < 50 && !exp_active; g++) tick();
    chk("exp_active_timeout", int'(exp_active), 1);
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 50 && (exp_active || bomb_active); g++) tick();
    chk("idle_timeout", int'(exp_active | bomb_active), 0);
  endtask

  // Count fuse/explode lengths from the current FUSE cycle onward
  task automatic run_bomb(input int already, output int fuse_len, output int exp_len,
                          output int starts, output int first_start);
    int g;
    fuse_len = already;
    exp_len  = 0;
    starts   = 0;
    g        = 0;
    while (bomb_active && g < 200) begin
      fuse_len++;
      starts += int'(exp_start);
      g++;
      tick();
    end
    first_start = int'(exp_start & exp_active);
    while (exp_active && g < 200) begin
      exp_len++;
      starts += int'(exp_start);
      g++;
      tick();
    end
    starts += int'(exp_start);
  endtask

  task automatic apply_vecs(input int grp, input int kind);
    for (int i = 0; i < 27; i++) begin
      if (vecs[i].grp == grp && vecs[i].kind == kind) begin
        x = vecs[i].px;
        y = vecs[i].py;
        #1;
        chk($sformatf("%s_g%0d_(%0d,%0d)", (kind == 0) ? "bomb_on" : "exp_on", grp,
                      vecs[i].px, vecs[i].py),
            (kind == 0) ? int'(bomb_on) : int'(exp_on), vecs[i].want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fl, el, st, fs, cnt_hi, cnt_st, exp_fuse;

    vecs[0]  = '{1, 0, 10'd88,  10'd56, 1};
    vecs[1]  = '{1, 0, 10'd80,  10'd48, 1};
    vecs[2]  = '{1, 0, 10'd95,  10'd63, 1};
    vecs[3]  = '{1, 0, 10'd79,  10'd56, 0};
    vecs[4]  = '{1, 0, 10'd96,  10'd56, 0};
    vecs[5]  = '{1, 0, 10'd88,  10'd47, 0};
    vecs[6]  = '{1, 0, 10'd88,  10'd64, 0};
    vecs[7]  = '{1, 1, 10'd88,  10'd56, 1};
    vecs[8]  = '{1, 1, 10'd88,  10'd40, 1};
    vecs[9]  = '{1, 1, 10'd88,  10'd32, 1};
    vecs[10] = '{1, 1, 10'd88,  10'd72, 1};
    vecs[11] = '{1, 1, 10'd72,  10'd56, 0};
    vecs[12] = '{1, 1, 10'd104, 10'd56, 0};
    vecs[13] = '{1, 1, 10'd88,  10'd88, 0};
    vecs[14] = '{1, 1, 10'd120, 10'd56, 0};
    vecs[15] = '{1, 1, 10'd88,  10'd31, 0};
    vecs[16] = '{1, 1, 10'd56,  10'd56, 0};
    vecs[17] = '{2, 1, 10'd56,  10'd40, 1};
    vecs[18] = '{2, 1, 10'd72,  10'd40, 1};
    vecs[19] = '{2, 1, 10'd56,  10'd56, 1};
    vecs[20] = '{2, 1, 10'd47,  10'd40, 0};
    vecs[21] = '{2, 1, 10'd56,  10'd31, 0};
    vecs[22] = '{2, 1, 10'd88,  10'd40, 0};
    vecs[23] = '{2, 1, 10'd72,  10'd56, 0};
    vecs[24] = '{2, 1, 10'd56,  10'd72, 0};
    vecs[25] = '{2, 0, 10'd48,  10'd32, 1};
    vecs[26] = '{2, 0, 10'd64,  10'd32, 0};

    reset = 1'b1; A = 1'b0; gameover = 1'b0;
    x_b = 10'd0; y_b = 10'd0; x = 10'd0; y = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bomb_active", int'(bomb_active), 0);
    chk("rst_exp_active", int'(exp_active), 0);
    chk("rst_exp_start", int'(exp_start), 0);
    chk("rst_bomb_col", int'(bomb_col), 0);
    chk("rst_bomb_row", int'(bomb_row), 0);
    reset = 1'b0;
    tick();

    // Placement latency and window lengths
    x_b = 10'd64; y_b = 10'd23;
    place_expect(1, 0);
    A = 1'b1;
    tick();
    chk("lat_edgeN", int'(bomb_active), 0);
    tick();
    chk("lat_edgeN1", int'(bomb_active), 0);
    tick();
    chk("lat_edgeN2", int'(bomb_active), 1);
    wait_bomb();
    tick();
    A = 1'b0;
    run_bomb(1, fl, el, st, fs);
    chk("fuse_len", fl, FUSE);
    chk("exp_len", el, EXPC);
    chk("exp_start_count", st, 1);
    chk("exp_start_first", fs, 1);

    // Held button places only one bomb
    repeat (3) tick();
    place_expect(1, 0);
    A = 1'b1;
    wait_bomb();
    run_bomb(0, fl, el, st, fs);
    chk("held_fuse_len", fl, FUSE);
    cnt_hi = 0;
    for (int i = 0; i < 15; i++) begin
      cnt_hi += int'(bomb_active);
      tick();
    end
    chk("held_no_requeue", cnt_hi, 0);
    A = 1'b0;
    tick(); tick();
    place_expect(1, 0);
    A = 1'b1;
    wait_bomb();

    // Gameover abort in fuse cycle 5, then A ignored while gameover high
    repeat (4) tick();
    chk("abort_pre", int'(bomb_active), 1);
    gameover = 1'b1;
    tick();
    chk("abort_bomb_active", int'(bomb_active), 0);
    chk("abort_exp_active", int'(exp_active), 0);
    cnt_hi = 0; cnt_st = 0;
    A = 1'b0;
    tick(); tick();
    A = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cnt_hi += int'(bomb_active | exp_active);
      cnt_st += int'(exp_start);
      tick();
    end
    chk("gameover_block", cnt_hi, 0);
    chk("gameover_no_start", cnt_st, 0);
    gameover = 1'b0;
    A = 1'b0;
    repeat (3) tick();

    // Centre (2,1): horizontal arms are pillars, vertical arms present
    x_b = 10'd72; y_b = 10'd31;
    place_expect(2, 1);
    A = 1'b1;
    wait_bomb();
    A = 1'b0;
    apply_vecs(1, 0);
    wait_exp();
    apply_vecs(1, 1);
    wait_idle();

    // Corner (0,0): left and up arms clipped
    x_b = 10'd40; y_b = 10'd15;
    place_expect(0, 0);
    A = 1'b1;
    wait_bomb();
    A = 1'b0;
    apply_vecs(2, 0);
    wait_exp();
    apply_vecs(2, 1);
    wait_idle();
    tick();

    // Second press in fuse cycle 3
    x_b = 10'd64; y_b = 10'd23;
    place_expect(1, 0);
    A = 1'b1;
    wait_bomb();
    A = 1'b0;
    tick(); tick();
    A = 1'b1;
`ifdef BOMB_REMOTE_EN
    exp_fuse = 5;
`else
    exp_fuse = FUSE;
`endif
    run_bomb(2, fl, el, st, fs);
    chk("remote_fuse_len", fl, exp_fuse);
    chk("remote_exp_len", el, EXPC);
    chk("remote_start_count", st, 1);
    A = 1'b0;
    repeat (3) tick();

    // Async reset in the middle of the explosion
    place_expect(1, 0);
    A = 1'b1;
    wait_bomb();
    A = 1'b0;
    wait_exp();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_exp_active", int'(exp_active), 0);
    chk("async_rst_col", int'(bomb_col), 0);
    tick();
    chk("async_rst_no_start", int'(exp_start), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", int'(bomb_active | exp_active | exp_start), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
